fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation RV32 core. It replaces the single-cycle core's tied-off, zero-latency instruction bus with a real AXI4-Lite read master. The block keeps multiple reads in flight, buffers returned instructions with their PCs in an in-order prefetch queue, and flushes on branch/jump redirect. It sits between the instruction bus and the decode stage.

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the RV32 core.
//
// Issues sequential AXI4-Lite reads, keeps several of them in flight, and buffers the returned
// instructions with their PCs in an in-order prefetch queue for decode. A redirect flushes the
// queue and restarts fetch at a new PC. Reads already issued when the redirect happens are still
// answered by the bus, so they are tracked as stale and their beats are dropped on arrival.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   redirect_valid/pc   single-cycle flush and restart at redirect_pc (bits [1:0] ignored)
//   ibus_ar*            AXI4-Lite read address channel (master side, registered outputs)
//   ibus_r*             AXI4-Lite read data channel (rready is high whenever out of reset)
//   out_valid/ready     queue head handshake toward decode
//   out_inst/pc/fault   queue head contents; fault is set when rresp was not OKAY
module fetch_unit #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter int unsigned          DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,

  output logic [XLEN-1:0] ibus_araddr,
  output logic            ibus_arvalid,
  input  logic            ibus_arready,
  input  logic [XLEN-1:0] ibus_rdata,
  input  logic [1:0]      ibus_rresp,
  input  logic            ibus_rvalid,
  output logic            ibus_rready,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [XLEN-1:0] PcStep      = XLEN'(4);
  localparam logic [XLEN-1:0] PcAlignMask = ~XLEN'(3);
  localparam logic [CW:0]     DepthLimit  = (CW + 1)'(DEPTH);

  // AR channel state. fetch_pc holds the address of the next request to be issued; it is
  // advanced when a request is placed on the bus, since the held request keeps its own copy in
  // araddr.
  logic            arvalid_q, arvalid_d;
  logic [XLEN-1:0] araddr_q, araddr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

  // Credit accounting.
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic [CW-1:0]   count_q, count_d;
  // The request sitting on AR when a redirect hit; it becomes stale once accepted.
  logic            pend_stale_q, pend_stale_d;

  // PC of the next non-stale R beat. Non-stale reads are issued sequentially from the last
  // redirect target, and responses are in order, so a single counter is enough.
  logic [XLEN-1:0] rpc_q, rpc_d;

  // Prefetch queue.
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     inst_q  [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic            fault_q [DEPTH];

  logic            ar_hs;
  logic            r_hs;
  logic            r_stale;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] next_pc;
  logic [CW:0]     occupancy;

  assign ibus_rready  = rst_n;
  assign ibus_arvalid = arvalid_q;
  assign ibus_araddr  = araddr_q;

  assign out_valid = (count_q != '0);
  assign out_inst  = inst_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];
  assign out_fault = fault_q[rd_ptr_q];

  always_comb begin
    ar_hs    = arvalid_q & ibus_arready;
    r_hs     = ibus_rvalid & rst_n;
    r_stale  = (stale_q != '0);
    // A beat landing in the redirect cycle belongs to the old stream and is flushed with it.
    push     = r_hs & ~r_stale & ~redirect_valid;
    pop      = out_valid & out_ready & ~redirect_valid;
    redir_pc = redirect_pc & PcAlignMask;
  end

  // Credits, stale accounting and queue pointers.
  always_comb begin
    inflight_d   = inflight_q + CW'(ar_hs) - CW'(r_hs);
    stale_d      = stale_q;
    pend_stale_d = pend_stale_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rpc_d        = rpc_q;

    if (redirect_valid) begin
      // Every read still outstanding after this edge belongs to the old stream.
      stale_d      = inflight_d;
      pend_stale_d = arvalid_q & ~ibus_arready;
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      rpc_d        = redir_pc;
    end else begin
      stale_d      = stale_q + CW'(ar_hs & pend_stale_q) - CW'(r_hs & r_stale);
      pend_stale_d = pend_stale_q & ~ar_hs;
      count_d      = count_q + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rpc_d    = rpc_q + PcStep;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  // AR issue. Credits are checked against next-state occupancy so that a request, once raised,
  // always has a queue slot reserved and never needs to be withdrawn.
  always_comb begin
    next_pc    = redirect_valid ? redir_pc : fetch_pc_q;
    occupancy  = {1'b0, inflight_d} + {1'b0, count_d};
    arvalid_d  = 1'b0;
    araddr_d   = araddr_q;
    fetch_pc_d = next_pc;

    if (arvalid_q && !ibus_arready) begin
      // Hold address and valid until accepted, even across a redirect.
      arvalid_d = 1'b1;
    end else if (occupancy < DepthLimit) begin
      arvalid_d  = 1'b1;
      araddr_d   = next_pc;
      fetch_pc_d = next_pc + PcStep;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arvalid_q    <= 1'b0;
      araddr_q     <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      inflight_q   <= '0;
      stale_q      <= '0;
      count_q      <= '0;
      pend_stale_q <= 1'b0;
      rpc_q        <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      stale_q      <= stale_d;
      count_q      <= count_d;
      pend_stale_q <= pend_stale_d;
      rpc_q        <= rpc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Queue storage needs no reset; count_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q]  <= ibus_rdata[31:0];
      pc_q[wr_ptr_q]    <= rpc_q;
      fault_q[wr_ptr_q] <= (ibus_rresp != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit with an in-order AXI4-Lite slave
// and a stream-level model of the expected instruction sequence.
module tb_fetch_unit;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ibus_araddr;
  logic        ibus_arvalid;
  logic        ibus_arready;
  logic [31:0] ibus_rdata;
  logic [1:0]  ibus_rresp;
  logic        ibus_rvalid;
  logic        ibus_rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (Depth)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ibus_araddr    (ibus_araddr),
    .ibus_arvalid   (ibus_arvalid),
    .ibus_arready   (ibus_arready),
    .ibus_rdata     (ibus_rdata),
    .ibus_rresp     (ibus_rresp),
    .ibus_rvalid    (ibus_rvalid),
    .ibus_rready    (ibus_rready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave memory image and error map.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic flt(input logic [31:0] a);
    return (a == 32'h0000_0008) || (a[7:2] == 6'h2B);
  endfunction

  // Slave: accepted addresses awaiting their R beat, in order, with earliest return cycle.
  logic [31:0] sq_addr[$];
  int          sq_due[$];

  // Stimulus knobs.
  bit          ar_low;
  bit          ar_rand;
  bit          rv_rand;
  int          or_mode;   // 0 hold low, 1 hold high, 2 random
  int unsigned lat_lo;
  int unsigned lat_hi;
  bit          redir_req;
  logic [31:0] redir_tgt;

  // Stream model and observation.
  logic [31:0] exp_pc;
  bit          got_first;
  logic [31:0] first_pc;
  int          n_pop;
  int          cyc;
  int          ar_cnt;
  logic [31:0] ar_log[$];
  bit          prev_pend;
  logic [31:0] prev_addr;
  bit          post_redir;

  // One clock cycle: check outputs, drive inputs, predict handshakes, advance.
  task automatic step();
    bit ar_hs;
    bit r_hs;
    bit pop;
    if (prev_pend) begin
      check_eq("ar_hold_valid", 32'(ibus_arvalid), 32'd1);
      check_eq("ar_hold_addr", ibus_araddr, prev_addr);
    end
    if (post_redir) check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    check_eq("inflight_cap", 32'(sq_addr.size() <= Depth), 32'd1);

    ibus_arready = ar_low ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    ibus_rvalid  = 1'b0;
    ibus_rdata   = 32'h0;
    ibus_rresp   = 2'b00;
    if (sq_addr.size() > 0 && sq_due[0] <= cyc && (!rv_rand || $urandom_range(0, 3) != 0)) begin
      ibus_rvalid = 1'b1;
      ibus_rdata  = mem_word(sq_addr[0]);
      ibus_rresp  = flt(sq_addr[0]) ? (sq_addr[0][2] ? 2'b11 : 2'b10) : 2'b00;
    end
    out_ready      = (or_mode == 1) ? 1'b1 :
                     (or_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    redirect_valid = redir_req;
    redirect_pc    = redir_tgt;
    redir_req      = 1'b0;

    ar_hs = ibus_arvalid & ibus_arready;
    r_hs  = ibus_rvalid & ibus_rready;
    pop   = out_valid & out_ready;

    if (pop && !redirect_valid) begin
      check_eq("out_pc", out_pc, exp_pc);
      check_eq("out_inst", out_inst, mem_word(exp_pc));
      check_eq("out_fault", 32'(out_fault), 32'(flt(exp_pc)));
      if (!got_first) begin
        got_first = 1'b1;
        first_pc  = out_pc;
      end
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (redirect_valid) begin
      exp_pc    = redir_tgt & ~32'h3;
      got_first = 1'b0;
    end
    if (ar_hs) begin
      sq_addr.push_back(ibus_araddr);
      sq_due.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
      ar_log.push_back(ibus_araddr);
      ar_cnt++;
    end
    if (r_hs && sq_addr.size() > 0) begin
      void'(sq_addr.pop_front());
      void'(sq_due.pop_front());
    end
    prev_pend  = ibus_arvalid & ~ibus_arready;
    prev_addr  = ibus_araddr;
    post_redir = redirect_valid;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ibus_arready   = 1'b0;
    ibus_rvalid    = 1'b0;
    ibus_rdata     = 32'h0;
    ibus_rresp     = 2'b00;
    out_ready      = 1'b0;
    sq_addr.delete();
    sq_due.delete();
    ar_log.delete();
    prev_pend  = 1'b0;
    post_redir = 1'b0;
    redir_req  = 1'b0;
    exp_pc     = 32'h0;
    got_first  = 1'b0;
    first_pc   = 32'h0;
    n_pop      = 0;
    ar_cnt     = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_arvalid", 32'(ibus_arvalid), 32'd0);
    check_eq("rst_araddr", ibus_araddr, 32'h0);
    check_eq("rst_rready", 32'(ibus_rready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    cyc = 0;
    ar_low = 1'b0; ar_rand = 1'b0; rv_rand = 1'b0;
    lat_lo = 1; lat_hi = 1; redir_tgt = 32'h0;

    // Zero-wait slave, decode always ready: back-to-back fetch, one instruction per cycle.
    or_mode = 1;
    do_reset();
    step();
    check_eq("first_ar_valid", 32'(ibus_arvalid), 32'd1);
    check_eq("first_ar_addr", ibus_araddr, 32'h0);
    repeat (4) step();
    for (int i = 0; i < 20; i++) begin
      check_eq("t1_stream_valid", 32'(out_valid), 32'd1);
      step();
    end
    check_eq("t1_ar_count", 32'(ar_log.size() >= 4), 32'd1);
    if (ar_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check_eq("t1_ar_seq", ar_log[i], 32'(4 * i));
    end
    check_eq("t1_pops", 32'(n_pop >= 20), 32'd1);

    // Decode stalled: credits cap fetch at DEPTH requests, then resume at 0x10.
    or_mode = 0;
    do_reset();
    repeat (20) step();
    check_eq("t2_ar_count", 32'(ar_cnt), Depth);
    check_eq("t2_arvalid_idle", 32'(ibus_arvalid), 32'd0);
    or_mode = 1;
    ar_log.delete();
    k = 0;
    while (ar_log.size() == 0 && k < 10) begin
      step();
      k++;
    end
    check_eq("t2_resume_seen", 32'(ar_log.size()), 32'd1);
    if (ar_log.size() > 0) check_eq("t2_resume_addr", ar_log[0], 32'h10);
    repeat (6) step();
    check_eq("t2_first_pc", first_pc, 32'h0);
    check_eq("t2_pops", 32'(n_pop >= 4), 32'd1);

    // Redirect with three reads in flight: their beats must be discarded.
    or_mode = 1; lat_lo = 4; lat_hi = 4;
    do_reset();
    k = 0;
    while (sq_addr.size() != 3 && k < 30) begin
      step();
      k++;
    end
    check_eq("t3_inflight3", 32'(sq_addr.size()), 32'd3);
    redir_req = 1'b1; redir_tgt = 32'h100;
    step();
    repeat (30) step();
    check_eq("t3_got_first", 32'(got_first), 32'd1);
    check_eq("t3_first_pc", first_pc, 32'h100);

    // Redirect while an AR is stalled: it must hold and complete, then fetch restarts at 0x200.
    lat_lo = 2; lat_hi = 2;
    do_reset();
    k = 0;
    while (!(ibus_arvalid && ibus_araddr == 32'h40) && k < 60) begin
      step();
      k++;
    end
    check_eq("t4_reach_40", ibus_araddr, 32'h40);
    ar_low = 1'b1;
    redir_req = 1'b1; redir_tgt = 32'h203;
    ar_log.delete();
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("t4_held_valid", 32'(ibus_arvalid), 32'd1);
      check_eq("t4_held_addr", ibus_araddr, 32'h40);
      step();
    end
    ar_low = 1'b0;
    k = 0;
    while (ar_log.size() < 2 && k < 20) begin
      step();
      k++;
    end
    check_eq("t4_ar_seen", 32'(ar_log.size() >= 2), 32'd1);
    if (ar_log.size() >= 2) begin
      check_eq("t4_stale_ar", ar_log[0], 32'h40);
      check_eq("t4_new_ar", ar_log[1], 32'h200);
    end
    repeat (20) step();
    check_eq("t4_first_pc", first_pc, 32'h200);

    // Address wrap at the top of the address space.
    lat_lo = 1; lat_hi = 1; or_mode = 0;
    do_reset();
    repeat (15) step();
    check_eq("t6_quiet_arvalid", 32'(ibus_arvalid), 32'd0);
    check_eq("t6_quiet_inflight", 32'(sq_addr.size()), 32'd0);
    or_mode = 1;
    redir_req = 1'b1; redir_tgt = 32'hFFFF_FFF8;
    ar_log.delete();
    repeat (13) step();
    check_eq("t6_ar_count", 32'(ar_log.size() >= 3), 32'd1);
    if (ar_log.size() >= 3) begin
      check_eq("t6_ar0", ar_log[0], 32'hFFFF_FFF8);
      check_eq("t6_ar1", ar_log[1], 32'hFFFF_FFFC);
      check_eq("t6_ar2", ar_log[2], 32'h0000_0000);
    end
    check_eq("t6_first_pc", first_pc, 32'hFFFF_FFF8);
    check_eq("t6_pops", 32'(n_pop >= 3), 32'd1);

    // Random bus timing, random decode back-pressure and random redirects.
    ar_rand = 1'b1; rv_rand = 1'b1; lat_lo = 1; lat_hi = 4; or_mode = 2;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        redir_req = 1'b1;
        redir_tgt = $urandom;
      end
      step();
    end
    check_eq("rand_progress", 32'(n_pop > 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timed out");
  end

endmodule
